cargador_bloque: RTL

CARGADOR_BLOQUE -- requirements
Module: cargador_bloque

---
 rtl/cargador_bloque.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cargador_bloque.sv
// cargador_bloque: loads a 12-byte block header and a 1-byte target from a
// byte stream, starts the miner and holds it until it reports a result or
// the cycle budget runs out, then keeps the result available until it is
// acknowledged. Every output comes straight from a register.
module cargador_bloque #(
   parameter int TIMEOUT = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        inicio,
   output logic [95:0] bloque_bytes,
   output logic [7:0]  target,
   input  logic        terminado,
   input  logic [23:0] hash,
   output logic [23:0] hash_out,
   output logic        hash_valid,
   input  logic        hash_ack,
   output logic [31:0] ciclos,
   output logic        expirado
);

   typedef enum logic [1:0] {
      RECIBIR  = 2'd0,
      MINAR    = 2'd1,
      ENTREGAR = 2'd2
   } estado_t;

   // Compared against ciclos+1, so it is kept one bit wider than ciclos.
   localparam logic [32:0] TIMEOUT_C = 33'(TIMEOUT);

   estado_t     r_state;
   estado_t     w_next;
   logic [3:0]  r_cnt;
   logic [95:0] r_bloque;
   logic [7:0]  r_target;
   logic [23:0] r_hash;
   logic [31:0] r_ciclos;
   logic        r_expirado;
   logic        r_byte_ready;
   logic        r_inicio;
   logic        r_hash_valid;
   logic [6:0]  w_lsb;
   logic [32:0] w_ciclos_inc;
   logic        w_timeout;

   // The first byte received ends up in the most significant byte.
   assign w_lsb        = 7'd88 - {r_cnt, 3'b000};
   assign w_ciclos_inc = {1'b0, r_ciclos} + 33'd1;
   assign w_timeout    = (w_ciclos_inc == TIMEOUT_C);

   // Next-state logic: the 13th byte starts mining, result or budget ends it,
   // acknowledge returns to loading.
   always_comb begin
      w_next = r_state;
      case (r_state)
         RECIBIR: begin
            if (byte_valid && (r_cnt == 4'd12)) begin
               w_next = MINAR;
            end else begin
               w_next = RECIBIR;
            end
         end
         MINAR: begin
            if (terminado || w_timeout) begin
               w_next = ENTREGAR;
            end else begin
               w_next = MINAR;
            end
         end
         ENTREGAR: begin
            if (hash_ack) begin
               w_next = RECIBIR;
            end else begin
               w_next = ENTREGAR;
            end
         end
         default: w_next = RECIBIR;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RECIBIR;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath: byte capture, cycle counting, result capture and the
   // state-decoded handshake outputs (registered from the next state).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= 4'd0;
         r_bloque     <= 96'd0;
         r_target     <= 8'd0;
         r_hash       <= 24'd0;
         r_ciclos     <= 32'd0;
         r_expirado   <= 1'b0;
         r_byte_ready <= 1'b1;
         r_inicio     <= 1'b0;
         r_hash_valid <= 1'b0;
      end else begin
         case (r_state)
            RECIBIR: begin
               if (byte_valid) begin
                  if (r_cnt == 4'd12) begin
                     r_target   <= byte_in;
                     r_cnt      <= 4'd0;
                     r_ciclos   <= 32'd0;
                     r_expirado <= 1'b0;
                  end else begin
                     r_bloque[w_lsb +: 8] <= byte_in;
                     r_cnt                <= r_cnt + 4'd1;
                  end
               end
            end
            MINAR: begin
               if (r_ciclos != 32'hFFFF_FFFF) begin
                  r_ciclos <= r_ciclos + 32'd1;
               end
               // A result on the budget's last cycle wins over the timeout.
               if (terminado) begin
                  r_hash <= hash;
               end else if (w_timeout) begin
                  r_hash     <= 24'd0;
                  r_expirado <= 1'b1;
               end
            end
            ENTREGAR: begin
               r_cnt <= 4'd0;
            end
            default: begin
               r_cnt <= 4'd0;
            end
         endcase
         r_byte_ready <= (w_next == RECIBIR);
         r_inicio     <= (w_next == MINAR);
         r_hash_valid <= (w_next == ENTREGAR);
      end
   end

   assign byte_ready   = r_byte_ready;
   assign inicio       = r_inicio;
   assign bloque_bytes = r_bloque;
   assign target       = r_target;
   assign hash_out     = r_hash;
   assign hash_valid   = r_hash_valid;
   assign ciclos       = r_ciclos;
   assign expirado     = r_expirado;

endmodule
